// File: rtl/dom_rand_pkg.sv
// Shared types and constants for the DOM GF(4) randomness generator:
// FSM states, LFSR feedback taps and the derived random-word width.
package dom_rand_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WARMUP,
    FILL,
    RUN
  } state_e;

  localparam int TAP0 = 63;
  localparam int TAP1 = 62;
  localparam int TAP2 = 60;
  localparam int TAP3 = 59;

  // An all-zero state would lock the LFSR, so a zero seed is replaced by this.
  localparam logic [63:0] ZERO_SEED_SUB = 64'h1;

  function automatic int rw_of(input int shares);
    return 2 * shares * (shares - 1) + 4 * shares;
  endfunction

endpackage

// File: rtl/lfsr64_multistep.sv
// Combinational unrolling of STEPS single steps of the 64-bit Fibonacci LFSR;
// bits_o[0] is the first feedback bit generated.
module lfsr64_multistep
  import dom_rand_pkg::*;
#(
  parameter int STEPS = 12
) (
  input  logic [63:0]      state_i,
  output logic [63:0]      next_o,
  output logic [STEPS-1:0] bits_o
);

  logic [63:0] s;
  logic        n;

  // NOTE: every variable written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    s      = state_i;
    n      = 1'b0;
    bits_o = '0;
    for (int k = 0; k < STEPS; k++) begin
      n         = s[TAP0] ^ s[TAP1] ^ s[TAP2] ^ s[TAP3];
      bits_o[k] = n;
      s         = {s[62:0], n};
    end
    next_o = s;
  end

endmodule

// File: rtl/dom_rand_gen_gf4.sv
// Fresh Z/B randomness source for masked GF(4) multipliers: seedable LFSR,
// warm-up after every seed, valid/ready output that never re-issues a word.
module dom_rand_gen_gf4
  import dom_rand_pkg::*;
#(
  parameter int SHARES        = 2,
  parameter int WARMUP_CYCLES = 4
) (
  input  logic                            ClkxCI,
  input  logic                            RstxRI,
  input  logic [63:0]                     SeedxDI,
  input  logic                            SeedValidxSI,
  output logic                            SeedReadyxSO,
  output logic [2*SHARES*(SHARES-1)-1:0]  ZxDO,
  output logic [4*SHARES-1:0]             BxDO,
  output logic                            ValidxSO,
  input  logic                            ReadyxSI,
  output logic [31:0]                     WordCntxDO
);

  localparam int ZW = 2 * SHARES * (SHARES - 1);
  localparam int BW = 4 * SHARES;
  localparam int RW = rw_of(SHARES);
  localparam logic [7:0] WARM_LAST = 8'(WARMUP_CYCLES - 1);

  state_e        state_q, state_d;
  logic [63:0]   lfsr_q, lfsr_d, lfsr_next;
  logic [RW-1:0] word;
  logic [ZW-1:0] z_q, z_d;
  logic [BW-1:0] b_q, b_d;
  logic          valid_q, valid_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [7:0]    warm_q, warm_d;

  logic          seed_ready;
  logic          seed_acc;
  logic          xfer;
  logic [63:0]   seed_g;

  lfsr64_multistep #(.STEPS(RW)) u_lfsr (
    .state_i (lfsr_q),
    .next_o  (lfsr_next),
    .bits_o  (word)
  );

  assign seed_ready = (state_q == IDLE) || (state_q == RUN);
  assign seed_acc   = SeedValidxSI && seed_ready;
  assign xfer       = valid_q && ReadyxSI;
  assign seed_g     = (SeedxDI == 64'h0) ? ZERO_SEED_SUB : SeedxDI;

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    z_d     = z_q;
    b_d     = b_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    warm_d  = warm_q;
    unique case (state_q)
      IDLE: begin
        if (seed_acc) begin
          lfsr_d  = seed_g;
          warm_d  = 8'd0;
          state_d = WARMUP;
        end
      end
      WARMUP: begin
        lfsr_d = lfsr_next;
        if (warm_q == WARM_LAST) state_d = FILL;
        else                     warm_d  = warm_q + 8'd1;
      end
      FILL: begin
        lfsr_d  = lfsr_next;
        z_d     = word[ZW-1:0];
        b_d     = word[RW-1:ZW];
        valid_d = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        // A transfer in the reseed cycle still completes and is counted.
        if (xfer) cnt_d = cnt_q + 32'd1;
        if (seed_acc) begin
          lfsr_d  = seed_g;
          warm_d  = 8'd0;
          valid_d = 1'b0;
          state_d = WARMUP;
        end else if (xfer) begin
          lfsr_d = lfsr_next;
          z_d    = word[ZW-1:0];
          b_d    = word[RW-1:ZW];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge ClkxCI or posedge RstxRI) begin
    if (RstxRI) begin
      state_q <= IDLE;
      lfsr_q  <= '0;
      z_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      warm_q  <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      z_q     <= z_d;
      b_q     <= b_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      warm_q  <= warm_d;
    end
  end

  assign SeedReadyxSO = seed_ready;
  assign ZxDO         = z_q;
  assign BxDO         = b_q;
  assign ValidxSO     = valid_q;
  assign WordCntxDO   = cnt_q;

endmodule

// File: tb/tb_dom_rand_gen_gf4.sv
// Directed/randomized bench for dom_rand_gen_gf4 against a bit-stream
// recurrence model of the LFSR kept as a 64-entry history queue.
module tb_dom_rand_gen_gf4;

  localparam int SHARES = 2;
  localparam int W      = 4;
  localparam int ZW     = 2 * SHARES * (SHARES - 1);
  localparam int BW     = 4 * SHARES;
  localparam int RW     = ZW + BW;

  logic          clk = 1'b0;
  logic          rst;
  logic [63:0]   seed;
  logic          seed_valid;
  logic          seed_ready;
  logic [ZW-1:0] z;
  logic [BW-1:0] b;
  logic          valid;
  logic          ready;
  logic [31:0]   cnt;

  int total = 0;
  int bad   = 0;

  dom_rand_gen_gf4 #(.SHARES(SHARES), .WARMUP_CYCLES(W)) dut (
    .ClkxCI       (clk),
    .RstxRI       (rst),
    .SeedxDI      (seed),
    .SeedValidxSI (seed_valid),
    .SeedReadyxSO (seed_ready),
    .ZxDO         (z),
    .BxDO         (b),
    .ValidxSO     (valid),
    .ReadyxSI     (ready),
    .WordCntxDO   (cnt)
  );

  always #5 clk = ~clk;

  // Model: generated bit = x[k-64]^x[k-63]^x[k-61]^x[k-60], oldest seed bit first.
  bit            hist[$];
  logic [RW-1:0] cur;
  logic [RW-1:0] w1_cur;
  logic [31:0]   exp_cnt;
  bit            run_valid;

  task automatic model_seed(input logic [63:0] sd);
    logic [63:0] s;
    s = (sd == 64'h0) ? 64'h1 : sd;
    hist.delete();
    for (int i = 63; i >= 0; i--) hist.push_back(s[i]);
  endtask

  task automatic model_word(output logic [RW-1:0] wd);
    bit n;
    wd = '0;
    for (int k = 0; k < RW; k++) begin
      n = hist[0] ^ hist[1] ^ hist[3] ^ hist[4];
      void'(hist.pop_front());
      hist.push_back(n);
      wd[k] = n;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a seed for one edge; model is advanced to the first output word.
  task automatic accept_seed(input logic [63:0] sd, input bit rdy);
    logic [RW-1:0] dummy;
    seed       = sd;
    seed_valid = 1'b1;
    ready      = rdy;
    if (rdy && run_valid) exp_cnt++;
    step();
    seed_valid = 1'b0;
    ready      = 1'b0;
    run_valid  = 1'b0;
    check("accept_valid_low", valid, 0);
    check("accept_seed_ready_low", seed_ready, 0);
    check("accept_cnt", cnt, exp_cnt);
    model_seed(sd);
    for (int i = 0; i < W; i++) model_word(dummy);
    model_word(cur);
  endtask

  task automatic wait_valid();
    for (int i = 1; i <= W; i++) begin
      step();
      check("warmup_valid_low", valid, 0);
      if (i < W) check("warmup_seed_ready_low", seed_ready, 0);
    end
    step();
    check("valid_rises", valid, 1);
    check("first_z", z, cur[ZW-1:0]);
    check("first_b", b, cur[RW-1:ZW]);
    run_valid = 1'b1;
  endtask

  task automatic take_words(input int n);
    for (int i = 0; i < n; i++) begin
      check("stream_z", z, cur[ZW-1:0]);
      check("stream_b", b, cur[RW-1:ZW]);
      ready = 1'b1;
      step();
      exp_cnt++;
      model_word(cur);
    end
    ready = 1'b0;
    check("stream_cnt", cnt, exp_cnt);
  endtask

  initial begin
    logic [63:0] seed_a, seed_b;
    bit          r;
    rst        = 1'b1;
    seed       = '0;
    seed_valid = 1'b0;
    ready      = 1'b0;
    exp_cnt    = '0;
    run_valid  = 1'b0;

    // Reset, then idle with no seed.
    repeat (3) step();
    rst = 1'b0;
    repeat (10) step();
    check("idle_valid", valid, 0);
    check("idle_z", z, 0);
    check("idle_b", b, 0);
    check("idle_seed_ready", seed_ready, 1);
    check("idle_cnt", cnt, 0);

    // Known word from seed 1: first 1-bit is generated at step 60.
    accept_seed(64'h1, 1'b0);
    wait_valid();
    check("known_z", z, 4'h0);
    check("known_b", b, 8'h80);
    w1_cur = cur;

    // Stall: word and count held.
    for (int i = 0; i < 20; i++) begin
      step();
      if (i % 5 == 4) begin
        check("stall_z", z, 4'h0);
        check("stall_b", b, 8'h80);
        check("stall_cnt", cnt, 0);
        check("stall_valid", valid, 1);
      end
    end
    take_words(3);
    check("three_words_cnt", cnt, 3);

    // Zero seed reseed in RUN: stream equals the seed-1 stream.
    accept_seed(64'h0, 1'b0);
    check("zero_seed_model_word", cur, w1_cur);
    wait_valid();
    take_words(4);

    // Reseed mid-run with a concurrent transfer.
    seed_a = {$urandom(), $urandom()};
    seed_b = {$urandom(), $urandom()};
    accept_seed(seed_a, 1'b0);
    wait_valid();
    take_words(5);
    accept_seed(seed_b, 1'b1);
    wait_valid();
    take_words(3);

    // Randomized consumer backpressure.
    for (int i = 0; i < 40; i++) begin
      r = 1'($urandom_range(0, 1));
      check("rand_valid", valid, 1);
      check("rand_z", z, cur[ZW-1:0]);
      check("rand_b", b, cur[RW-1:ZW]);
      ready = r;
      step();
      if (r) begin
        exp_cnt++;
        model_word(cur);
      end
    end
    ready = 1'b0;
    check("rand_cnt", cnt, exp_cnt);

    // Asynchronous reset between edges during warm-up.
    accept_seed({$urandom(), $urandom()}, 1'b0);
    step();
    #2 rst = 1'b1;
    #1;
    check("arst_valid", valid, 0);
    check("arst_z", z, 0);
    check("arst_b", b, 0);
    check("arst_cnt", cnt, 0);
    check("arst_seed_ready", seed_ready, 1);
    #2 rst = 1'b0;
    exp_cnt   = '0;
    run_valid = 1'b0;
    step();
    step();
    check("post_arst_idle_valid", valid, 0);
    accept_seed(64'h1, 1'b0);
    wait_valid();
    check("post_arst_known_z", z, 4'h0);
    check("post_arst_known_b", b, 8'h80);
    take_words(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dom_rand_gen_gf4.md
Name: dom_rand_gen_gf4

Overview:
- Supplies the fresh randomness consumed by the masked GF(4) multipliers of the DOM AES S-box: one inter-domain remask word Z plus one blinding word B per transfer.
- Built on a seedable 64-bit LFSR that is advanced several steps per cycle.
- Feeds the multipliers through a valid/ready handshake, with a seed-load handshake on its input side.
- Owns the warm-up, stall, zero-seed and reseed behaviour so the multipliers can treat Z/B as always-fresh.

Parameters:
- SHARES, 2, number of masking shares; must match the multipliers being fed.
- WARMUP_CYCLES, 4, number of cycles whose LFSR output is discarded after each seed load; range 1..255.
- ZW, 2*SHARES*(SHARES-1), derived Z width; not overridable.
- BW, 4*SHARES, derived B width; not overridable.
- RW, ZW+BW, derived width of one random word; must be ≤ 64. SHARES=2 gives RW=12.

Ports:
- ClkxCI  in  1  clock.
- RstxRI  in  1  asynchronous active-high reset.
- SeedxDI  in  64  LFSR seed.
- SeedValidxSI  in  1  seed offered.
- SeedReadyxSO  out  1  seed can be accepted.
- ZxDO  out  ZW  remask word; goes to the multiplier Z input.
- BxDO  out  BW  blinding word; goes to the multiplier B input.
- ValidxSO  out  1  Z/B word valid.
- ReadyxSI  in  1  consumer takes the word this cycle.
- WordCntxDO  out  32  count of delivered words; wraps at 2^32.

Behaviour:
- Reset:
  - Asserting RstxRI clears all state asynchronously.
  - FSM enters IDLE; LFSR=0; ZxDO=0; BxDO=0; ValidxSO=0; WordCntxDO=0; warm-up counter=0; SeedReadyxSO=1.
- LFSR step (single step), state s[63:0]:
  - n = s[63]^s[62]^s[60]^s[59].
  - s <= {s[62:0], n}.
- Per cycle:
  - When a cycle advances the LFSR, it takes exactly RW single steps.
  - The RW generated bits n form word w, first-generated bit in w[0].
  - ZxDO = w[ZW-1:0]; BxDO = w[RW-1:ZW].
- Seed acceptance:
  - A seed is accepted when SeedValidxSI && SeedReadyxSO.
  - SeedReadyxSO = 1 in IDLE and RUN, 0 in WARMUP.
  - An all-zero seed is replaced by 64'h1; the LFSR never holds 0 outside reset/IDLE.
- FSM:
  - IDLE: outputs held at 0, ValidxSO=0. On seed accept: LFSR<=seed, counter<=0, go to WARMUP.
  - WARMUP: each cycle the LFSR advances and the word is discarded, counter+1. When counter reaches WARMUP_CYCLES-1, go to FILL.
  - FILL: the LFSR advances once, the word is loaded into the output register, ValidxSO<=1, go to RUN.
  - RUN, with ValidxSO && ReadyxSI:
    - The LFSR advances and the next word is registered in the same cycle; ValidxSO stays 1 (back-to-back, one word per cycle).
    - WordCntxDO increments.
  - RUN, with ValidxSO && !ReadyxSI: stall. ZxDO, BxDO and the LFSR are held unchanged, so the same randomness is never re-issued after a transfer.
  - Reseed in RUN: seed accept has priority over everything else.
    - ValidxSO<=0 next cycle; any pending word is dropped and not counted.
    - LFSR<=seed (zero-guarded); go to WARMUP.
    - If ReadyxSI is high in the same cycle, that transfer still completes and is counted.
- Latency: seed accepted at edge t → ValidxSO rises at edge t+WARMUP_CYCLES+1. The LFSR has then taken (WARMUP_CYCLES+1)*RW steps.
- Reset mid-operation: returns to IDLE immediately; a new seed is required before any output.
- WordCntxDO is never cleared by a reseed, only by reset.

Decomposition:
- Package dom_rand_pkg:
  - FSM state enum {IDLE, WARMUP, FILL, RUN};
  - LFSR tap constants (63, 62, 60, 59);
  - zero-seed replacement constant 64'h1;
  - function rw_of(shares).
- Sub-module lfsr64_multistep #(STEPS):
  - purely combinational;
  - inputs: state; outputs: next state and the STEPS generated bits;
  - instantiated once with STEPS=RW.

Test Plan:
- Reset then idle: RstxRI pulse, no seed for 10 cycles → ValidxSO=0, ZxDO=0, BxDO=0, SeedReadyxSO=1, WordCntxDO=0.
- Known word: SHARES=2, WARMUP_CYCLES=4, seed 64'h1 accepted at edge t, ReadyxSI=0 → ValidxSO rises at t+5 with ZxDO=4'h0, BxDO=8'h80 (step 60 is the first 1-bit).
- Stall: hold ReadyxSI=0 for 20 cycles after valid → ZxDO/BxDO stay 4'h0/8'h80, WordCntxDO=0. Then ReadyxSI=1 for 3 cycles → 3 distinct words matching the golden LFSR model, WordCntxDO=3.
- Zero seed: seed 64'h0 → output stream is bit-identical to the seed 64'h1 run.
- Reseed mid-run: seed A, stream 5 words, present seed B with ReadyxSI=1 → the 6th transfer is counted, ValidxSO=0 for WARMUP_CYCLES+1 cycles, the stream restarts from the B golden sequence, WordCntxDO continues from 6. SeedReadyxSO=0 throughout WARMUP.
- Async reset mid-WARMUP: assert RstxRI between clock edges → all outputs 0 immediately, FSM IDLE; a subsequent seed 64'h1 reproduces the known-word result.
